// File: rtl/icache_linefill_ctrl.sv
// Linefill responder for the icache MSHR: forwards linefill requests downstream,
// assembles the returning beats into a full line, writes it to the data RAM and pulses done.
module icache_linefill_ctrl #(
    parameter int MSHR_ENTRY_NUM = 8,
    parameter int WAY_NUM        = 4,
    parameter int INDEX_WIDTH    = 7,
    parameter int ADDR_WIDTH     = 32,
    parameter int BEAT_WIDTH     = 128,
    parameter int LINE_BEATS     = 4,
    localparam int ENTRY_ID_W    = $clog2(MSHR_ENTRY_NUM),
    localparam int LINE_WIDTH    = BEAT_WIDTH * LINE_BEATS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      txreq_vld,
    output logic                      txreq_rdy,
    input  logic [ENTRY_ID_W-1:0]     txreq_entry_id,
    input  logic                      txreq_lineA,
    input  logic [ADDR_WIDTH-1:0]     txreq_addr,
    input  logic [INDEX_WIDTH-1:0]    txreq_index,
    input  logic [WAY_NUM-1:0]        txreq_way,
    output logic                      bus_req_vld,
    input  logic                      bus_req_rdy,
    output logic [ADDR_WIDTH-1:0]     bus_req_addr,
    output logic [ENTRY_ID_W:0]       bus_req_txnid,
    input  logic                      rxdat_vld,
    output logic                      rxdat_rdy,
    input  logic [ENTRY_ID_W:0]       rxdat_txnid,
    input  logic [BEAT_WIDTH-1:0]     rxdat_data,
    output logic                      dataram_wr_vld,
    input  logic                      dataram_wr_rdy,
    output logic [INDEX_WIDTH-1:0]    dataram_wr_index,
    output logic [WAY_NUM-1:0]        dataram_wr_way,
    output logic [LINE_WIDTH-1:0]     dataram_wr_data,
    output logic [MSHR_ENTRY_NUM-1:0] v_linefillA_done,
    output logic [MSHR_ENTRY_NUM-1:0] v_linefillB_done,
    output logic                      ost_empty,
    output logic                      proto_err
);

    localparam int SLOT_NUM = 2 * MSHR_ENTRY_NUM;
    localparam int CNT_W    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ENTRY_ID_W:0]       txnid_q, txnid_d;
    logic [LINE_WIDTH-1:0]     line_q, line_d;
    logic [SLOT_NUM-1:0]       slot_vld_q, slot_vld_d;
    logic [INDEX_WIDTH-1:0]    slot_idx_q [SLOT_NUM];
    logic [INDEX_WIDTH-1:0]    slot_idx_d [SLOT_NUM];
    logic [WAY_NUM-1:0]        slot_way_q [SLOT_NUM];
    logic [WAY_NUM-1:0]        slot_way_d [SLOT_NUM];
    logic                      rxdat_rdy_q, rxdat_rdy_d;
    logic                      wr_vld_q, wr_vld_d;
    logic [MSHR_ENTRY_NUM-1:0] done_a_q, done_a_d;
    logic [MSHR_ENTRY_NUM-1:0] done_b_q, done_b_d;
    logic                      proto_err_q, proto_err_d;
    logic                      ost_empty_q, ost_empty_d;

    logic [ENTRY_ID_W:0]       req_slot;
    logic                      busy;
    logic                      req_hs;
    logic                      beat_hs;

    // Request path is a pure pass-through; a busy slot holds the request off without dropping it.
    assign req_slot      = {txreq_entry_id, txreq_lineA};
    assign busy          = slot_vld_q[req_slot];
    assign bus_req_vld   = txreq_vld & ~busy;
    assign txreq_rdy     = bus_req_rdy & ~busy;
    assign bus_req_addr  = txreq_addr;
    assign bus_req_txnid = req_slot;
    assign req_hs        = txreq_vld & txreq_rdy;
    assign beat_hs       = rxdat_vld & rxdat_rdy_q;

    assign rxdat_rdy        = rxdat_rdy_q;
    assign dataram_wr_vld   = wr_vld_q;
    assign dataram_wr_index = slot_idx_q[txnid_q];
    assign dataram_wr_way   = slot_way_q[txnid_q];
    assign dataram_wr_data  = line_q;
    assign v_linefillA_done = done_a_q;
    assign v_linefillB_done = done_b_q;
    assign ost_empty        = ost_empty_q;
    assign proto_err        = proto_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txnid_d     = txnid_q;
        line_d      = line_q;
        slot_vld_d  = slot_vld_q;
        slot_idx_d  = slot_idx_q;
        slot_way_d  = slot_way_q;
        rxdat_rdy_d = rxdat_rdy_q;
        wr_vld_d    = wr_vld_q;
        done_a_d    = '0;
        done_b_d    = '0;
        proto_err_d = 1'b0;

        if (req_hs) begin
            slot_vld_d[req_slot] = 1'b1;
            slot_idx_d[req_slot] = txreq_index;
            slot_way_d[req_slot] = txreq_way;
        end

        case (state_q)
            IDLE: begin
                if (beat_hs) begin
                    if (slot_vld_q[rxdat_txnid]) begin
                        txnid_d               = rxdat_txnid;
                        line_d[0 +: BEAT_WIDTH] = rxdat_data;
                        cnt_d                 = CNT_W'(1);
                        if (LINE_BEATS == 1) begin
                            state_d     = WRITE;
                            rxdat_rdy_d = 1'b0;
                            wr_vld_d    = 1'b1;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (beat_hs) begin
                    // Beats never interleave across lines, so any other txnid is a stray.
                    if (rxdat_txnid == txnid_q) begin
                        for (int i = 0; i < LINE_BEATS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                line_d[i*BEAT_WIDTH +: BEAT_WIDTH] = rxdat_data;
                            end
                        end
                        if (cnt_q == CNT_W'(LINE_BEATS - 1)) begin
                            state_d     = WRITE;
                            rxdat_rdy_d = 1'b0;
                            wr_vld_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (dataram_wr_rdy) begin
                    slot_vld_d[txnid_q] = 1'b0;
                    done_a_d[txnid_q[ENTRY_ID_W:1]] = txnid_q[0];
                    done_b_d[txnid_q[ENTRY_ID_W:1]] = ~txnid_q[0];
                    wr_vld_d    = 1'b0;
                    rxdat_rdy_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rxdat_rdy_d = 1'b1;
                wr_vld_d    = 1'b0;
            end
        endcase

        ost_empty_d = ~|slot_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            txnid_q     <= '0;
            line_q      <= '0;
            slot_vld_q  <= '0;
            for (int i = 0; i < SLOT_NUM; i++) begin
                slot_idx_q[i] <= '0;
                slot_way_q[i] <= '0;
            end
            rxdat_rdy_q <= 1'b1;
            wr_vld_q    <= 1'b0;
            done_a_q    <= '0;
            done_b_q    <= '0;
            proto_err_q <= 1'b0;
            ost_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txnid_q     <= txnid_d;
            line_q      <= line_d;
            slot_vld_q  <= slot_vld_d;
            slot_idx_q  <= slot_idx_d;
            slot_way_q  <= slot_way_d;
            rxdat_rdy_q <= rxdat_rdy_d;
            wr_vld_q    <= wr_vld_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            proto_err_q <= proto_err_d;
            ost_empty_q <= ost_empty_d;
        end
    end

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed bench for icache_linefill_ctrl: fills, ordering, busy slots, backpressure,
// stray beats and mid-line reset, each checked with immediate assertions.
module tb_icache_linefill_ctrl;

    localparam int LW = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         txreq_vld = 1'b0;
    logic         txreq_rdy;
    logic [2:0]   txreq_entry_id = '0;
    logic         txreq_lineA = 1'b0;
    logic [31:0]  txreq_addr = '0;
    logic [6:0]   txreq_index = '0;
    logic [3:0]   txreq_way = '0;
    logic         bus_req_vld;
    logic         bus_req_rdy = 1'b0;
    logic [31:0]  bus_req_addr;
    logic [3:0]   bus_req_txnid;
    logic         rxdat_vld = 1'b0;
    logic         rxdat_rdy;
    logic [3:0]   rxdat_txnid = '0;
    logic [127:0] rxdat_data = '0;
    logic         dataram_wr_vld;
    logic         dataram_wr_rdy = 1'b0;
    logic [6:0]   dataram_wr_index;
    logic [3:0]   dataram_wr_way;
    logic [511:0] dataram_wr_data;
    logic [7:0]   v_linefillA_done;
    logic [7:0]   v_linefillB_done;
    logic         ost_empty;
    logic         proto_err;

    int total = 0;
    int bad   = 0;

    icache_linefill_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .txreq_vld        (txreq_vld),
        .txreq_rdy        (txreq_rdy),
        .txreq_entry_id   (txreq_entry_id),
        .txreq_lineA      (txreq_lineA),
        .txreq_addr       (txreq_addr),
        .txreq_index      (txreq_index),
        .txreq_way        (txreq_way),
        .bus_req_vld      (bus_req_vld),
        .bus_req_rdy      (bus_req_rdy),
        .bus_req_addr     (bus_req_addr),
        .bus_req_txnid    (bus_req_txnid),
        .rxdat_vld        (rxdat_vld),
        .rxdat_rdy        (rxdat_rdy),
        .rxdat_txnid      (rxdat_txnid),
        .rxdat_data       (rxdat_data),
        .dataram_wr_vld   (dataram_wr_vld),
        .dataram_wr_rdy   (dataram_wr_rdy),
        .dataram_wr_index (dataram_wr_index),
        .dataram_wr_way   (dataram_wr_way),
        .dataram_wr_data  (dataram_wr_data),
        .v_linefillA_done (v_linefillA_done),
        .v_linefillB_done (v_linefillB_done),
        .ost_empty        (ost_empty),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] e, input logic a, input logic [31:0] ad,
                       input logic [6:0] ix, input logic [3:0] w);
        txreq_vld      = 1'b1;
        txreq_entry_id = e;
        txreq_lineA    = a;
        txreq_addr     = ad;
        txreq_index    = ix;
        txreq_way      = w;
    endtask

    task automatic beat(input logic [3:0] id, input logic [127:0] d);
        rxdat_vld   = 1'b1;
        rxdat_txnid = id;
        rxdat_data  = d;
        tick();
        rxdat_vld   = 1'b0;
    endtask

    task automatic four_beats(input logic [3:0] id, input logic [127:0] base);
        for (int i = 0; i < 4; i++) beat(id, base + 128'(i));
    endtask

    function automatic logic [LW-1:0] mkline(input logic [127:0] base);
        return {base + 128'd3, base + 128'd2, base + 128'd1, base};
    endfunction

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_txreq_rdy", LW'(txreq_rdy), LW'(0));
        chk("rst_bus_req_vld", LW'(bus_req_vld), LW'(0));
        chk("rst_rxdat_rdy", LW'(rxdat_rdy), LW'(1));
        chk("rst_wr_vld", LW'(dataram_wr_vld), LW'(0));
        chk("rst_doneA", LW'(v_linefillA_done), LW'(0));
        chk("rst_doneB", LW'(v_linefillB_done), LW'(0));
        chk("rst_proto_err", LW'(proto_err), LW'(0));
        chk("rst_ost_empty", LW'(ost_empty), LW'(1));
        rst_n = 1'b1;
        tick();

        // Line A fill, entry 3
        bus_req_rdy = 1'b1;
        req(3'd3, 1'b1, 32'h1000, 7'd5, 4'b0010);
        #1;
        chk("t1_bus_req_vld", LW'(bus_req_vld), LW'(1));
        chk("t1_txreq_rdy", LW'(txreq_rdy), LW'(1));
        chk("t1_txnid", LW'(bus_req_txnid), LW'(4'b0111));
        chk("t1_addr", LW'(bus_req_addr), LW'(32'h1000));
        tick();
        txreq_vld = 1'b0;
        chk("t1_ost_busy", LW'(ost_empty), LW'(0));
        four_beats(4'b0111, 128'hA0);
        chk("t1_wr_vld", LW'(dataram_wr_vld), LW'(1));
        chk("t1_rxdat_rdy_wr", LW'(rxdat_rdy), LW'(0));
        chk("t1_wr_data", dataram_wr_data, mkline(128'hA0));
        chk("t1_wr_index", LW'(dataram_wr_index), LW'(5));
        chk("t1_wr_way", LW'(dataram_wr_way), LW'(4'b0010));
        dataram_wr_rdy = 1'b1;
        tick();
        dataram_wr_rdy = 1'b0;
        chk("t1_doneA", LW'(v_linefillA_done), LW'(8'h08));
        chk("t1_doneB", LW'(v_linefillB_done), LW'(0));
        chk("t1_wr_vld_off", LW'(dataram_wr_vld), LW'(0));
        chk("t1_ost_empty", LW'(ost_empty), LW'(1));
        chk("t1_rxdat_rdy", LW'(rxdat_rdy), LW'(1));
        tick();
        chk("t1_doneA_clr", LW'(v_linefillA_done), LW'(0));

        // A then B for entry 1, B data returns first
        req(3'd1, 1'b1, 32'h2000, 7'd10, 4'b0001);
        #1;
        chk("t2_rdyA", LW'(txreq_rdy), LW'(1));
        tick();
        req(3'd1, 1'b0, 32'h2040, 7'd11, 4'b0100);
        #1;
        chk("t2_rdyB", LW'(txreq_rdy), LW'(1));
        chk("t2_txnidB", LW'(bus_req_txnid), LW'(4'b0010));
        tick();
        txreq_vld = 1'b0;
        dataram_wr_rdy = 1'b1;
        four_beats(4'b0010, 128'hB0);
        chk("t2_B_data", dataram_wr_data, mkline(128'hB0));
        chk("t2_B_index", LW'(dataram_wr_index), LW'(11));
        chk("t2_B_way", LW'(dataram_wr_way), LW'(4'b0100));
        tick();
        chk("t2_doneB", LW'(v_linefillB_done), LW'(8'h02));
        chk("t2_doneA_quiet", LW'(v_linefillA_done), LW'(0));
        tick();
        chk("t2_doneB_clr", LW'(v_linefillB_done), LW'(0));
        four_beats(4'b0011, 128'hC0);
        chk("t2_A_data", dataram_wr_data, mkline(128'hC0));
        chk("t2_A_index", LW'(dataram_wr_index), LW'(10));
        tick();
        chk("t2_doneA", LW'(v_linefillA_done), LW'(8'h02));
        chk("t2_doneB_quiet", LW'(v_linefillB_done), LW'(0));
        tick();
        chk("t2_doneA_clr", LW'(v_linefillA_done), LW'(0));
        dataram_wr_rdy = 1'b0;

        // Busy slot plus write backpressure, entry 2 line A
        req(3'd2, 1'b1, 32'h3000, 7'd20, 4'b1000);
        tick();
        req(3'd2, 1'b1, 32'h3100, 7'd21, 4'b0001);
        #1;
        chk("t3_busy_rdy", LW'(txreq_rdy), LW'(0));
        chk("t3_busy_vld", LW'(bus_req_vld), LW'(0));
        for (int i = 0; i < 4; i++) begin
            chk("t3_busy_beat", LW'(txreq_rdy), LW'(0));
            beat(4'b0101, 128'hD0 + 128'(i));
        end
        for (int i = 0; i < 5; i++) begin
            chk("t3_bp_wr_vld", LW'(dataram_wr_vld), LW'(1));
            chk("t3_bp_data", dataram_wr_data, mkline(128'hD0));
            chk("t3_bp_rxrdy", LW'(rxdat_rdy), LW'(0));
            chk("t3_bp_busy", LW'(bus_req_vld), LW'(0));
            tick();
        end
        dataram_wr_rdy = 1'b1;
        #1;
        chk("t3_hs_busy", LW'(txreq_rdy), LW'(0));
        tick();
        dataram_wr_rdy = 1'b0;
        chk("t3_doneA", LW'(v_linefillA_done), LW'(8'h04));
        chk("t3_free_rdy", LW'(txreq_rdy), LW'(1));
        chk("t3_free_vld", LW'(bus_req_vld), LW'(1));
        chk("t3_free_addr", LW'(bus_req_addr), LW'(32'h3100));
        tick();
        txreq_vld = 1'b0;
        chk("t3_doneA_clr", LW'(v_linefillA_done), LW'(0));
        chk("t3_ost_busy", LW'(ost_empty), LW'(0));
        four_beats(4'b0101, 128'hE0);
        chk("t3_2nd_data", dataram_wr_data, mkline(128'hE0));
        chk("t3_2nd_index", LW'(dataram_wr_index), LW'(21));
        chk("t3_2nd_way", LW'(dataram_wr_way), LW'(4'b0001));
        dataram_wr_rdy = 1'b1;
        tick();
        dataram_wr_rdy = 1'b0;
        chk("t3_2nd_doneA", LW'(v_linefillA_done), LW'(8'h04));
        tick();

        // Stray beat to an unallocated slot, then a fill with a mismatched beat mid-line
        beat(4'b1011, 128'hEE);
        chk("t4_proto_err", LW'(proto_err), LW'(1));
        chk("t4_ost_empty", LW'(ost_empty), LW'(1));
        tick();
        chk("t4_proto_clr", LW'(proto_err), LW'(0));
        chk("t4_no_wr", LW'(dataram_wr_vld), LW'(0));
        chk("t4_no_done", LW'(v_linefillA_done), LW'(0));
        req(3'd5, 1'b1, 32'h5000, 7'd7, 4'b0010);
        tick();
        txreq_vld = 1'b0;
        beat(4'b1011, 128'hF0);
        beat(4'b1011, 128'hF1);
        beat(4'b1010, 128'hBAD);
        chk("t4_mid_err", LW'(proto_err), LW'(1));
        beat(4'b1011, 128'hF2);
        beat(4'b1011, 128'hF3);
        chk("t4_data", dataram_wr_data, mkline(128'hF0));
        chk("t4_proto_quiet", LW'(proto_err), LW'(0));
        dataram_wr_rdy = 1'b1;
        tick();
        dataram_wr_rdy = 1'b0;
        chk("t4_doneA", LW'(v_linefillA_done), LW'(8'h20));
        tick();

        // Reset after 2 of 4 beats, then a fresh fill
        req(3'd6, 1'b0, 32'h6000, 7'd3, 4'b0100);
        tick();
        txreq_vld = 1'b0;
        beat(4'b1100, 128'h70);
        beat(4'b1100, 128'h71);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_ost_empty", LW'(ost_empty), LW'(1));
        chk("t5_no_wr", LW'(dataram_wr_vld), LW'(0));
        chk("t5_rxdat_rdy", LW'(rxdat_rdy), LW'(1));
        tick();
        tick();
        chk("t5_no_done", LW'(v_linefillB_done), LW'(0));
        rst_n = 1'b1;
        tick();
        req(3'd6, 1'b0, 32'h6000, 7'd3, 4'b0100);
        #1;
        chk("t5_slot_free", LW'(txreq_rdy), LW'(1));
        tick();
        txreq_vld = 1'b0;
        four_beats(4'b1100, 128'h90);
        chk("t5_data", dataram_wr_data, mkline(128'h90));
        chk("t5_index", LW'(dataram_wr_index), LW'(3));
        dataram_wr_rdy = 1'b1;
        tick();
        dataram_wr_rdy = 1'b0;
        chk("t5_doneB", LW'(v_linefillB_done), LW'(8'h40));
        tick();
        chk("t5_doneB_clr", LW'(v_linefillB_done), LW'(0));
        chk("t5_ost_end", LW'(ost_empty), LW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
